heap_deq_fsm: RTL and testbench

- Dequeue (sift-down) controller for the QuickQ BRAM binary min-heap; the read-side counterpart of the enqueue/sift-up control FSM.
- On a dequeue request it removes the root (lowest key) entry, moves the last entry to the root, and sifts it down until the heap property holds.
- It drives the heap BRAM read/write port and decrements the shared entry counter.

---
 rtl/quickq_pkg.sv | 32 +++
 rtl/heap_child_sel.sv | 37 +++
 rtl/heap_deq_fsm.sv | 170 +++++++++++++++++
 tb/tb_heap_deq_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quickq_pkg.sv
// Shared QuickQ heap types, default widths and the key ordering used by
// both the enqueue and dequeue controllers.
package quickq_pkg;

    localparam int unsigned KEY_W     = 16;
    localparam int unsigned ENTRY_W   = 32;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned PAYLOAD_W = ENTRY_W - KEY_W;

    typedef enum logic [3:0] {
        DEQ_IDLE,
        DEQ_RD_LAST,
        DEQ_LOAD_LAST,
        DEQ_RD_L,
        DEQ_RD_R,
        DEQ_CMP_R,
        DEQ_CMP,
        DEQ_WRITE,
        DEQ_DONE
    } deq_state_t;

    typedef struct packed {
        logic [KEY_W-1:0]     key;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    // Strict unsigned compare: equal keys are never "less", so ties never move.
    function automatic logic key_less(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/heap_child_sel.sv
// Holds the smaller of a left/right child pair as the two reads return;
// the left child is kept on a key tie.
module heap_child_sel
    import quickq_pkg::*;
#(
    parameter int unsigned KEY_W   = quickq_pkg::KEY_W,
    parameter int unsigned ENTRY_W = quickq_pkg::ENTRY_W,
    parameter int unsigned ADDR_W  = quickq_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_left,
    input  logic               ld_right,
    input  logic [ADDR_W:0]    left_idx,
    input  logic [ENTRY_W-1:0] rd_data,
    output logic [ENTRY_W-1:0] best,
    output logic [ADDR_W:0]    best_idx
);

    logic right_wins;

    assign right_wins = key_less(rd_data[ENTRY_W-1 -: KEY_W], best[ENTRY_W-1 -: KEY_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            best     <= '0;
            best_idx <= '0;
        end else if (ld_left) begin
            best     <= rd_data;
            best_idx <= left_idx;
        end else if (ld_right && right_wins) begin
            best     <= rd_data;
            best_idx <= left_idx + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: rtl/heap_deq_fsm.sv
// Dequeue (sift-down) controller for the QuickQ BRAM min-heap: removes the
// root, moves the last entry to the root and sifts it down.
module heap_deq_fsm
    import quickq_pkg::*;
#(
    parameter int unsigned KEY_W   = quickq_pkg::KEY_W,
    parameter int unsigned ENTRY_W = quickq_pkg::ENTRY_W,
    parameter int unsigned ADDR_W  = quickq_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               deq,
    input  logic [ADDR_W:0]    count,
    output logic               ready,
    output logic               done,
    output logic               underflow,
    output logic [ENTRY_W-1:0] deq_data,
    output logic               countenb,
    output logic               re,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [ENTRY_W-1:0] rd_data,
    output logic               we,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ENTRY_W-1:0] wr_data
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    deq_state_t         state, next_state;
    logic [IDX_W-1:0]   n_q, idx_q, left_idx, right_idx, best_idx;
    logic [ENTRY_W-1:0] cur_q, best;
    logic               latch_n, cap_root, load_cur, advance;
    logic               ld_left, ld_right, underflow_nx;

    assign left_idx  = (idx_q << 1) | IDX_W'(1);
    assign right_idx = left_idx + IDX_W'(1);

    heap_child_sel #(
        .KEY_W   (KEY_W),
        .ENTRY_W (ENTRY_W),
        .ADDR_W  (ADDR_W)
    ) u_child_sel (
        .clk      (clk),
        .rst      (rst),
        .ld_left  (ld_left),
        .ld_right (ld_right),
        .left_idx (left_idx),
        .rd_data  (rd_data),
        .best     (best),
        .best_idx (best_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DEQ_IDLE;
        else     state <= next_state;
    end

    // BRAM port is driven in-state so read data lines up with the next state;
    // held quiet while rst is high so a reset cannot land a stray write.
    always_comb begin
        next_state   = state;
        re           = 1'b0;
        rd_addr      = '0;
        we           = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        latch_n      = 1'b0;
        cap_root     = 1'b0;
        load_cur     = 1'b0;
        advance      = 1'b0;
        ld_left      = 1'b0;
        ld_right     = 1'b0;
        underflow_nx = 1'b0;
        if (!rst) begin
            case (state)
                DEQ_IDLE: begin
                    if (deq) begin
                        if (count == '0) begin
                            underflow_nx = 1'b1;
                        end else begin
                            re         = 1'b1;
                            latch_n    = 1'b1;
                            next_state = DEQ_RD_LAST;
                        end
                    end
                end
                DEQ_RD_LAST: begin
                    cap_root   = 1'b1;
                    re         = 1'b1;
                    rd_addr    = ADDR_W'(n_q);
                    next_state = DEQ_LOAD_LAST;
                end
                DEQ_LOAD_LAST: begin
                    load_cur   = 1'b1;
                    next_state = (n_q == '0) ? DEQ_DONE : DEQ_RD_L;
                end
                DEQ_RD_L: begin
                    if (left_idx >= n_q) begin
                        next_state = DEQ_WRITE;
                    end else begin
                        re         = 1'b1;
                        rd_addr    = ADDR_W'(left_idx);
                        next_state = DEQ_RD_R;
                    end
                end
                DEQ_RD_R: begin
                    ld_left = 1'b1;
                    if (right_idx < n_q) begin
                        re         = 1'b1;
                        rd_addr    = ADDR_W'(right_idx);
                        next_state = DEQ_CMP_R;
                    end else begin
                        next_state = DEQ_CMP;
                    end
                end
                DEQ_CMP_R: begin
                    ld_right   = 1'b1;
                    next_state = DEQ_CMP;
                end
                DEQ_CMP: begin
                    if (key_less(best[ENTRY_W-1 -: KEY_W], cur_q[ENTRY_W-1 -: KEY_W])) begin
                        we         = 1'b1;
                        wr_addr    = ADDR_W'(idx_q);
                        wr_data    = best;
                        advance    = 1'b1;
                        next_state = DEQ_RD_L;
                    end else begin
                        next_state = DEQ_WRITE;
                    end
                end
                DEQ_WRITE: begin
                    we         = 1'b1;
                    wr_addr    = ADDR_W'(idx_q);
                    wr_data    = cur_q;
                    next_state = DEQ_DONE;
                end
                DEQ_DONE: next_state = DEQ_IDLE;
                default:  next_state = DEQ_IDLE;
            endcase
        end
    end

    // Status pulses are registered from the next state so they coincide with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready     <= 1'b1;
            done      <= 1'b0;
            countenb  <= 1'b0;
            underflow <= 1'b0;
            deq_data  <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            cur_q     <= '0;
        end else begin
            ready     <= (next_state == DEQ_IDLE);
            done      <= (next_state == DEQ_DONE);
            countenb  <= (next_state == DEQ_LOAD_LAST);
            underflow <= underflow_nx;
            if (latch_n)  n_q      <= count - IDX_W'(1);
            if (cap_root) deq_data <= rd_data;
            if (load_cur) begin
                cur_q <= rd_data;
                idx_q <= '0;
            end else if (advance) begin
                idx_q <= best_idx;
            end
        end
    end

endmodule

// File: tb/tb_heap_deq_fsm.sv
// Bench for heap_deq_fsm: BRAM model, hand vectors, corner sequences and
// randomized heaps checked against a queue-based min-heap model.
module tb_heap_deq_fsm;
    import quickq_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned EW = 32;
    localparam int unsigned KW = 16;

    logic          clk = 1'b0;
    logic          rst, deq;
    logic [AW:0]   count;
    logic          ready, done, underflow, countenb, re, we;
    logic [EW-1:0] deq_data, rd_data, wr_data;
    logic [AW-1:0] rd_addr, wr_addr;

    logic [EW-1:0] mem [0:1023];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [EW-1:0] pl_data;

    int n_cmp = 0;
    int n_bad = 0;
    int r_lat, r_we, r_re, r_ce, r_done, r_uf, r_notready, r_overlap;
    logic r_ready_end;
    logic [EW-1:0] ref_h[$];

    typedef struct packed {
        logic [7:0]      cnt;
        logic [0:7][7:0] keys;
        logic [7:0]      exp_key;
        logic [7:0]      exp_lat;
        logic [7:0]      exp_we;
        logic            exp_uf;
        logic [0:7][7:0] after;
    } vec_t;

    vec_t vecs[4];

    heap_deq_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .deq       (deq),
        .count     (count),
        .ready     (ready),
        .done      (done),
        .underflow (underflow),
        .deq_data  (deq_data),
        .countenb  (countenb),
        .re        (re),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we)   mem[pl_addr] <= pl_data;
        else if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end

    function automatic logic [KW-1:0] key_of(input logic [EW-1:0] e);
        return e[EW-1 -: KW];
    endfunction

    function automatic logic [EW-1:0] mk(input int key, input int pay);
        entry_t e;
        e.key     = KW'(key);
        e.payload = 16'(pay);
        return e;
    endfunction

    function automatic vec_t mkv(input int cnt, input logic [0:7][7:0] keys, input int ek,
                                 input int lat, input int nwe, input bit uf,
                                 input logic [0:7][7:0] after);
        vec_t v;
        v.cnt = 8'(cnt); v.keys = keys; v.exp_key = 8'(ek); v.exp_lat = 8'(lat);
        v.exp_we = 8'(nwe); v.exp_uf = uf; v.after = after;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_ref();
        for (int i = 0; i < ref_h.size(); i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = AW'(i); pl_data = ref_h[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic ref_insert(input logic [EW-1:0] e);
        int i, p;
        logic [EW-1:0] t;
        ref_h.push_back(e);
        i = ref_h.size() - 1;
        while (i > 0) begin
            p = (i - 1) / 2;
            if (key_of(ref_h[i]) >= key_of(ref_h[p])) break;
            t = ref_h[i]; ref_h[i] = ref_h[p]; ref_h[p] = t;
            i = p;
        end
    endtask

    // Remove the minimum: last entry replaces the root and sinks below any
    // strictly smaller child (left child preferred on a tie).
    task automatic model_deq(output logic [EW-1:0] root);
        int i, l, c;
        logic [EW-1:0] last;
        root = ref_h[0];
        last = ref_h.pop_back();
        if (ref_h.size() == 0) return;
        i = 0;
        while (1) begin
            l = 2 * i + 1;
            if (l >= ref_h.size()) break;
            c = l;
            if (l + 1 < ref_h.size() && key_of(ref_h[l+1]) < key_of(ref_h[l])) c = l + 1;
            if (key_of(ref_h[c]) >= key_of(last)) break;
            ref_h[i] = ref_h[c];
            i = c;
        end
        ref_h[i] = last;
    endtask

    task automatic sample_cycle(input int c);
        if (re)        r_re++;
        if (we)        r_we++;
        if (countenb)  r_ce++;
        if (underflow) r_uf++;
        if (!ready)    r_notready++;
        if (re && we)  r_overlap++;
        if (done) begin
            r_done++;
            if (r_lat < 0) r_lat = c;
        end
    endtask

    // Pulse deq once and watch until done/underflow plus two quiet cycles.
    task automatic run_deq(input bit noisy);
        int end_c;
        r_lat = -1; r_we = 0; r_re = 0; r_ce = 0; r_done = 0; r_uf = 0;
        r_notready = 0; r_overlap = 0; end_c = -1;
        @(negedge clk); deq = 1'b1; #1; sample_cycle(0);
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            deq = (noisy && end_c < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1; sample_cycle(c);
            if (end_c < 0 && (r_lat >= 0 || r_uf > 0)) end_c = c;
            if (end_c >= 0 && c >= end_c + 2) break;
        end
        deq = 1'b0;
        r_ready_end = ready;
    endtask

    initial begin
        logic [EW-1:0] exp_root;
        int wes, dones, sz, bad, bound;
        logic [0:4][7:0] drain_keys;

        rst = 1'b1; deq = 1'b0; count = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        check("reset_flags", {ready, done, underflow, countenb, re, we}, 6'b100000);
        check("reset_addr_data", {rd_addr, wr_addr, wr_data, deq_data}, '0);

        vecs[0] = mkv(5, {8'd3, 8'd5, 8'd8, 8'd9, 8'd6, 8'd0, 8'd0, 8'd0}, 3, 11, 2, 1'b0,
                      {8'd5, 8'd6, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0});
        vecs[1] = mkv(1, {8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 7, 3, 0, 1'b0, '0);
        vecs[2] = mkv(0, '0, 0, 0, 0, 1'b1, '0);
        vecs[3] = mkv(4, {8'd1, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}, 1, 8, 1, 1'b0,
                      {8'd4, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

        for (int v = 0; v < 4; v++) begin
            ref_h.delete();
            for (int i = 0; i < int'(vecs[v].cnt); i++)
                ref_h.push_back(mk(int'(vecs[v].keys[i]), 16'h5000 + i));
            load_ref();
            count = (AW+1)'(vecs[v].cnt);
            run_deq(1'b0);
            check($sformatf("v%0d_overlap", v), r_overlap, 0);
            check($sformatf("v%0d_ready_end", v), r_ready_end, 1);
            if (vecs[v].exp_uf) begin
                check($sformatf("v%0d_underflow", v), r_uf, 1);
                check($sformatf("v%0d_no_bus", v), r_re + r_we, 0);
                check($sformatf("v%0d_no_countenb", v), r_ce, 0);
                check($sformatf("v%0d_no_done", v), r_done, 0);
                check($sformatf("v%0d_ready_held", v), r_notready, 0);
            end else begin
                check($sformatf("v%0d_deq_key", v), key_of(deq_data), vecs[v].exp_key);
                check($sformatf("v%0d_latency", v), r_lat, vecs[v].exp_lat);
                check($sformatf("v%0d_writes", v), r_we, vecs[v].exp_we);
                check($sformatf("v%0d_countenb", v), r_ce, 1);
                check($sformatf("v%0d_done", v), r_done, 1);
                check($sformatf("v%0d_no_underflow", v), r_uf, 0);
                for (int i = 0; i < int'(vecs[v].cnt) - 1; i++)
                    check($sformatf("v%0d_mem%0d_key", v, i), key_of(mem[i]), vecs[v].after[i]);
                if (v == 3) check("tie_root_from_last", mem[0][15:0], 16'h5003);
            end
        end

        // Drain a 5-entry heap, letting countenb walk the count down.
        ref_h.delete();
        ref_h = '{mk(3, 0), mk(5, 1), mk(8, 2), mk(9, 3), mk(6, 4)};
        load_ref();
        count = 5;
        drain_keys = {8'd3, 8'd5, 8'd6, 8'd8, 8'd9};
        for (int k = 0; k < 5; k++) begin
            run_deq(1'b0);
            check($sformatf("drain%0d_key", k), key_of(deq_data), drain_keys[k]);
            count = count - (AW+1)'(r_ce);
        end
        check("drain_count_zero", count, 0);
        run_deq(1'b0);
        check("drain_underflow", r_uf, 1);

        // Reset asserted while the first compare of the 5-entry heap is in flight.
        ref_h = '{mk(3, 0), mk(5, 1), mk(8, 2), mk(9, 3), mk(6, 4)};
        load_ref();
        count = 5;
        wes = 0;
        @(negedge clk); deq = 1'b1; #1; if (we) wes++;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); deq = 1'b0;
            if (c == 6) rst = 1'b1;
            #1; if (we) wes++;
        end
        check("rst_no_write", wes, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_ready", ready, 1);
        check("rst_we", we, 0);
        dones = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        check("rst_no_done", dones, 0);
        check("rst_mem_untouched", key_of(mem[0]), 3);

        // Random heaps drained to empty, with deq chatter while busy.
        for (int h = 0; h < 25; h++) begin
            ref_h.delete();
            sz = $urandom_range(1, 24);
            for (int i = 0; i < sz; i++) ref_insert(mk($urandom_range(0, 15), $urandom_range(0, 65535)));
            load_ref();
            while (ref_h.size() > 0) begin
                count = (AW+1)'(ref_h.size());
                bound = 5 + 4 * $clog2(ref_h.size() + 1);
                model_deq(exp_root);
                run_deq(1'b1);
                check("rand_deq_data", deq_data, exp_root);
                check("rand_countenb", r_ce, 1);
                check("rand_done", r_done, 1);
                check("rand_overlap", r_overlap, 0);
                check("rand_lat_bound", (r_lat >= 3 && r_lat <= bound), 1);
                bad = 0;
                for (int i = 0; i < ref_h.size(); i++) if (mem[i] !== ref_h[i]) bad++;
                check("rand_heap_contents", bad, 0);
            end
            count = '0;
            run_deq(1'b0);
            check("rand_underflow", r_uf, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
